pie_decoder: RTL and testbench

PIE_DECODER -- requirements
Module: pie_decoder

---
 rtl/pie_decoder.sv | 198 +++++++++++++++++++
 tb/tb_pie_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pie_decoder.sv
// PIE decoder: times rising-edge intervals on the synchronised line, calibrates
// from the Tari/RTcal(/TRcal) preamble and emits one strobed bit per symbol.
module pie_decoder #(
    parameter int CNT_W     = 10,
    parameter int DELIM_MIN = 15,
    parameter int DELIM_MAX = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pie,
    output logic             o_bit,
    output logic             o_bit_valid,
    output logic             o_frame_start,
    output logic             o_preamble,
    output logic [CNT_W-1:0] o_trcal,
    output logic             o_frame_end,
    output logic             o_err
);

    typedef enum logic [2:0] {
        IDLE,
        DELIM,
        TARI,
        RTCAL,
        CAL3,
        DATA
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] D_MIN    = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] D_MAX    = CNT_W'(DELIM_MAX);
    localparam logic [CNT_W-1:0] D_MIN_M1 = CNT_W'(DELIM_MIN - 1);

    state_t state, state_d;

    logic pie_meta, pie_sync, pie_prev;
    logic rise, fall;

    logic [CNT_W-1:0] cnt;      // cycles since the last synchronised rising edge
    logic [CNT_W-1:0] low_cnt;  // cycles since the last synchronised falling edge
    logic [CNT_W-1:0] tari, tari_d;
    logic [CNT_W-1:0] rtcal, rtcal_d;
    logic [CNT_W-1:0] pivot;
    logic [CNT_W-1:0] trcal_d;
    logic [CNT_W+1:0] end_limit;

    logic bit_d, valid_d, start_d, pre_d, end_d, err_d;
    logic sat;

    // NOTE: every flop here, synchroniser included, is updated with <= so all
    // stages sample the value from before the edge; = would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pie_meta <= 1'b1;
            pie_sync <= 1'b1;
            pie_prev <= 1'b1;
        end else begin
            pie_meta <= i_pie;
            pie_sync <= pie_meta;
            pie_prev <= pie_sync;
        end
    end

    assign rise = pie_sync & ~pie_prev;
    assign fall = ~pie_sync & pie_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            low_cnt <= '0;
        end else begin
            if (rise)
                cnt <= CNT_ONE;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_ONE;

            if (fall)
                low_cnt <= CNT_ONE;
            else if (low_cnt != CNT_MAX)
                low_cnt <= low_cnt + CNT_ONE;
        end
    end

    assign pivot = {1'b0, rtcal[CNT_W-1:1]};

    // TRcal may legitimately run up to 3x RTcal with the line high for most of
    // it, so the end-of-frame timeout is stretched while waiting for it.
    assign end_limit = (state == CAL3) ? (({2'b00, rtcal} << 1) + {2'b00, rtcal})
                                       : {2'b00, rtcal};

    // In DELIM the line is low, so the low counter is the one that can run away.
    assign sat = (state == DELIM) ? (low_cnt == CNT_MAX) : (cnt == CNT_MAX);

    // NOTE: all outputs of this block get a default first, so no path can leave
    // a variable unassigned and infer a latch.
    always_comb begin
        state_d = state;
        tari_d  = tari;
        rtcal_d = rtcal;
        trcal_d = o_trcal;
        pre_d   = o_preamble;
        bit_d   = o_bit;
        valid_d = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        err_d   = 1'b0;

        if (state != IDLE && sat) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fall)
                        state_d = DELIM;
                end
                DELIM: begin
                    if (rise) begin
                        if (low_cnt >= D_MIN && low_cnt <= D_MAX) begin
                            state_d = TARI;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                TARI: begin
                    if (rise) begin
                        tari_d  = cnt;
                        state_d = RTCAL;
                    end
                end
                RTCAL: begin
                    if (rise) begin
                        rtcal_d = cnt;
                        if (cnt <= tari) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = CAL3;
                        end
                    end
                end
                CAL3, DATA: begin
                    if (rise) begin
                        state_d = DATA;
                        if (state == CAL3) begin
                            start_d = 1'b1;
                            pre_d   = (cnt > rtcal);
                        end
                        if (state == DATA || cnt <= rtcal) begin
                            valid_d = 1'b1;
                            bit_d   = (cnt >= pivot);
                        end else begin
                            trcal_d = cnt;
                        end
                    end else if (pie_sync && {2'b00, cnt} == end_limit) begin
                        end_d   = 1'b1;
                        state_d = IDLE;
                    end else if (!pie_sync && !fall && low_cnt == D_MIN_M1) begin
                        // Low has now lasted DELIM_MIN cycles: treat it as a new delimiter.
                        err_d   = 1'b1;
                        state_d = DELIM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tari          <= '0;
            rtcal         <= '0;
            o_trcal       <= '0;
            o_preamble    <= 1'b0;
            o_bit         <= 1'b0;
            o_bit_valid   <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state         <= state_d;
            tari          <= tari_d;
            rtcal         <= rtcal_d;
            o_trcal       <= trcal_d;
            o_preamble    <= pre_d;
            o_bit         <= bit_d;
            o_bit_valid   <= valid_d;
            o_frame_start <= start_d;
            o_frame_end   <= end_d;
            o_err         <= err_d;
        end
    end

endmodule

// File: tb/tb_pie_decoder.sv
// Bench for pie_decoder: table of frames plus hand-built corner sequences;
// expected strobes go into a scoreboard queue and are matched as they appear.
module tb_pie_decoder;

    localparam int CNT_W = 10;
    localparam int PW    = 8;  // low pulse width at the end of each PIE symbol

    localparam logic [3:0] K_START = 4'b1000;
    localparam logic [3:0] K_BIT   = 4'b0100;
    localparam logic [3:0] K_END   = 4'b0010;
    localparam logic [3:0] K_ERR   = 4'b0001;

    logic             clk;
    logic             rst_n;
    logic             i_pie;
    logic             o_bit;
    logic             o_bit_valid;
    logic             o_frame_start;
    logic             o_preamble;
    logic [CNT_W-1:0] o_trcal;
    logic             o_frame_end;
    logic             o_err;

    pie_decoder #(
        .CNT_W    (CNT_W),
        .DELIM_MIN(15),
        .DELIM_MAX(40)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pie        (i_pie),
        .o_bit        (o_bit),
        .o_bit_valid  (o_bit_valid),
        .o_frame_start(o_frame_start),
        .o_preamble   (o_preamble),
        .o_trcal      (o_trcal),
        .o_frame_end  (o_frame_end),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] kind;
        logic       b;
        logic       pre;
        int         trcal;
        int         gap;   // cycles since previous strobe, -1 = not checked
    } ev_t;

    typedef struct packed {
        int          delim;
        int          tari;
        int          rtcal;
        int          trcal;
        int          nbits;
        logic [15:0] i0;
        logic [15:0] i1;
        logic [15:0] i2;
        logic [15:0] i3;
        logic        exp_err;
        logic        exp_pre;
        int          exp_trcal;
        logic [3:0]  exp_bits;
    } frame_t;

    ev_t    exp_q[$];
    frame_t tbl[8];
    int     n_cmp  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    int     last   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] k, input logic b, input logic p,
                        input int tr, input int gap);
        ev_t e;
        e.kind  = k;
        e.b     = b;
        e.pre   = p;
        e.trcal = tr;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic lvl, input int n);
        i_pie = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic sym(input int n);
        hold(1'b1, n - PW);
        hold(1'b0, PW);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_bit"}, o_bit, 0);
        check({tag, "_bit_valid"}, o_bit_valid, 0);
        check({tag, "_frame_start"}, o_frame_start, 0);
        check({tag, "_preamble"}, o_preamble, 0);
        check({tag, "_frame_end"}, o_frame_end, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_trcal"}, o_trcal, 0);
    endtask

    function automatic frame_t mk(input int d, input int t, input int r, input int tr,
                                  input int n, input int a0, input int a1, input int a2,
                                  input int a3, input logic e, input logic p,
                                  input int etr, input logic [3:0] eb);
        frame_t f;
        f.delim = d;  f.tari = t;  f.rtcal = r;  f.trcal = tr;  f.nbits = n;
        f.i0 = 16'(a0);  f.i1 = 16'(a1);  f.i2 = 16'(a2);  f.i3 = 16'(a3);
        f.exp_err = e;  f.exp_pre = p;  f.exp_trcal = etr;  f.exp_bits = eb;
        return f;
    endfunction

    function automatic int iv_at(input frame_t f, input int i);
        case (i)
            0:       return int'(f.i0);
            1:       return int'(f.i1);
            2:       return int'(f.i2);
            default: return int'(f.i3);
        endcase
    endfunction

    task automatic apply_frame(input frame_t f, input string tag);
        int first;
        if (f.exp_err) begin
            push(K_ERR, 1'b0, 1'b0, 0, -1);
        end else begin
            if (f.exp_pre) begin
                push(K_START, 1'b0, 1'b1, f.exp_trcal, -1);
                first = 0;
            end else begin
                push(K_START | K_BIT, f.exp_bits[0], 1'b0, f.exp_trcal, -1);
                first = 1;
            end
            for (int i = first; i < f.nbits; i++)
                push(K_BIT, f.exp_bits[i], 1'b0, 0, iv_at(f, i));
            push(K_END, 1'b0, 1'b0, 0, f.rtcal);
        end

        hold(1'b0, f.delim);
        if (f.tari > 0)  sym(f.tari);
        if (f.rtcal > 0) sym(f.rtcal);
        if (f.trcal > 0) sym(f.trcal);
        for (int i = 0; i < f.nbits; i++) sym(iv_at(f, i));
        hold(1'b1, 1);
        drain();
        check({tag, "_held_preamble"}, o_preamble, f.exp_pre);
        check({tag, "_held_trcal"}, o_trcal, f.exp_trcal);
    endtask

    // Scoreboard monitor: samples 1 time unit after each rising edge.
    initial begin
        ev_t        e;
        logic [3:0] kind;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            kind = {o_frame_start, o_bit_valid, o_frame_end, o_err};
            if (rst_n && kind != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", kind, 4'b0000);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", kind, e.kind);
                    if (e.kind[2]) check("bit_value", o_bit, e.b);
                    if (e.kind[3]) begin
                        check("start_preamble", o_preamble, e.pre);
                        check("start_trcal", o_trcal, e.trcal);
                    end
                    if (e.gap >= 0) check("strobe_spacing", cyc - last, e.gap);
                end
                last = cyc;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        //            delim tari rtcal trcal n  i0  i1  i2  i3 err pre etr  bits
        tbl[0] = mk(25, 20, 56, 100, 3, 20, 36, 20, 0,  0, 1, 100, 4'b0010);
        tbl[1] = mk(25, 20, 56, 0,   2, 36, 20, 0,  0,  0, 0, 100, 4'b0001);
        tbl[2] = mk(25, 20, 56, 0,   3, 27, 28, 27, 0,  0, 0, 100, 4'b0010);
        tbl[3] = mk(10, 0,  0,  0,   0, 0,  0,  0,  0,  1, 0, 100, 4'b0000);
        tbl[4] = mk(45, 0,  0,  0,   0, 0,  0,  0,  0,  1, 0, 100, 4'b0000);
        tbl[5] = mk(30, 24, 60, 150, 4, 29, 30, 45, 12, 0, 1, 150, 4'b0110);
        tbl[6] = mk(25, 20, 18, 0,   0, 0,  0,  0,  0,  1, 1, 150, 4'b0000);
        tbl[7] = mk(25, 20, 20, 0,   0, 0,  0,  0,  0,  1, 1, 150, 4'b0000);

        rst_n = 1'b0;
        i_pie = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 8; k++) apply_frame(tbl[k], $sformatf("frame%0d", k));

        // Long low inside DATA aborts and doubles as the next frame's delimiter.
        push(K_START | K_BIT, 1'b1, 1'b0, 150, -1);
        push(K_ERR, 1'b0, 1'b0, 0, 34);
        push(K_START, 1'b0, 1'b1, 100, -1);
        push(K_BIT, 1'b0, 1'b0, 0, 20);
        push(K_END, 1'b0, 1'b0, 0, 56);
        hold(1'b0, 25); sym(20); sym(56); sym(36);
        hold(1'b1, 20); hold(1'b0, 25);
        sym(20); sym(56); sym(100); sym(20);
        hold(1'b1, 1);
        drain();

        // Line stuck low after a delimiter start: exactly one saturation error.
        push(K_ERR, 1'b0, 1'b0, 0, -1);
        hold(1'b0, 1100);
        hold(1'b1, 1);
        drain();

        // Reset pulse after the second data bit aborts silently.
        push(K_START, 1'b0, 1'b1, 100, -1);
        push(K_BIT, 1'b0, 1'b0, 0, 20);
        push(K_BIT, 1'b1, 1'b0, 0, 36);
        hold(1'b0, 25); sym(20); sym(56); sym(100); sym(20); sym(36);
        hold(1'b1, 10);
        rst_n = 1'b0;
        hold(1'b1, 2);
        check_quiet("midreset");
        rst_n = 1'b1;
        hold(1'b1, 100);
        check("midreset_queue", exp_q.size(), 0);
        apply_frame(mk(25, 20, 56, 0, 2, 36, 20, 0, 0, 0, 0, 0, 4'b0001), "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
